// File: rtl/sram_device_model.sv
// Cycle-level SRAM device model: reads drive DQ after READ_LAT stable cycles, writes commit after WRITE_LAT.
// Defining SRAM_MODEL_INIT_CLEAR_EN adds a reset-time sweep that zeroes every word while busy is high.
module sram_device_model #(
  parameter int DEPTH_LOG2 = 8,
  parameter int READ_LAT   = 3,
  parameter int WRITE_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] SRAM_ADDR,
  input  logic        SRAM_WE_N,
  inout  wire  [63:0] SRAM_DQ,
  output logic        busy
);

  // state    | meaning
  // INIT     | zeroing sweep, one word per cycle (clear-enable builds only)
  // IDLE     | first edge after reset, loads the presented access unconditionally
  // RD_WAIT  | read window counting stable cycles
  // RD_DRIVE | read data captured, DQ driven while the access is unchanged
  // WR_WAIT  | write window counting stable cycles
  // WR_DONE  | write committed, waiting for the access to change
  typedef enum logic [2:0] {INIT, IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_DONE} state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] RD_LAT_C = 4'(READ_LAT);
  localparam logic [3:0] WR_LAT_C = 4'(WRITE_LAT);

  state_t                state;
  logic [16:0]           addr_q;
  logic                  we_q;
  logic [3:0]            cnt;
  logic [63:0]           rd_data;
  logic [63:0]           mem [DEPTH];

  logic                  changed;
  logic                  dq_oe;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [63:0]           mem_wdata;
  logic [DEPTH_LOG2-1:0] addr_idx;

`ifdef SRAM_MODEL_INIT_CLEAR_EN
  logic [DEPTH_LOG2-1:0] init_idx;
  assign busy = (state == INIT) && !rst;
`else
  assign busy = 1'b0;
`endif

  assign addr_idx = addr_q[DEPTH_LOG2-1:0];
  assign changed  = (SRAM_ADDR != addr_q) || (SRAM_WE_N != we_q);

  // Combinational enable so the bus lets go in the very cycle the access changes or reset rises.
  assign dq_oe   = !rst && (state == RD_DRIVE) && SRAM_WE_N && (SRAM_ADDR == addr_q);
  assign SRAM_DQ = dq_oe ? rd_data : 'z;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_idx;
    mem_wdata = SRAM_DQ;
    if (!rst) begin
`ifdef SRAM_MODEL_INIT_CLEAR_EN
      if (state == INIT) begin
        mem_we    = 1'b1;
        mem_waddr = init_idx;
        mem_wdata = '0;
      end
`endif
      if ((state == WR_WAIT) && !changed && (cnt == WR_LAT_C)) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage has no reset so contents survive reset unless the sweep clears them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef SRAM_MODEL_INIT_CLEAR_EN
      state    <= INIT;
      init_idx <= '0;
`else
      state    <= IDLE;
`endif
      addr_q  <= '0;
      we_q    <= 1'b1;
      cnt     <= '0;
      rd_data <= '0;
    end else if (state == INIT) begin
`ifdef SRAM_MODEL_INIT_CLEAR_EN
      init_idx <= init_idx + 1'b1;
      if (&init_idx) begin
        state <= IDLE;
      end
`else
      state <= IDLE;
`endif
    end else if ((state == IDLE) || changed) begin
      addr_q <= SRAM_ADDR;
      we_q   <= SRAM_WE_N;
      cnt    <= 4'd1;
      state  <= SRAM_WE_N ? RD_WAIT : WR_WAIT;
    end else begin
      case (state)
        RD_WAIT: begin
          if (cnt == RD_LAT_C) begin
            rd_data <= mem[addr_idx];
            state   <= RD_DRIVE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_WAIT: begin
          if (cnt == WR_LAT_C) begin
            state <= WR_DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_device_model.sv
// Bench for sram_device_model: directed scenarios plus random access windows against a window-age reference.
// Builds with or without SRAM_MODEL_INIT_CLEAR_EN.
module tb_sram_device_model;

  localparam int DEPTH_LOG2 = 8;
  localparam int READ_LAT   = 3;
  localparam int WRITE_LAT  = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef SRAM_MODEL_INIT_CLEAR_EN
  localparam int INIT_CYCLES = DEPTH;
`else
  localparam int INIT_CYCLES = 0;
`endif
  localparam logic [16:0] PARK = 17'h1FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] sram_addr = '0;
  logic        sram_we_n = 1'b1;
  logic        tb_dq_en = 1'b0;
  logic [63:0] tb_dq = '0;
  wire  [63:0] dq_bus;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference: memory as an array plus the age of the current access window.
  logic [63:0] ref_mem [DEPTH];
  bit          ref_known [DEPTH];
  bit          m_fresh = 1'b1;
  bit          m_drv = 1'b0;
  bit          m_rd_known = 1'b0;
  logic [63:0] m_rd = '0;
  logic [16:0] m_addr = '0;
  logic        m_we = 1'b1;
  int          m_age = 0;
  int          m_init = 0;

  assign dq_bus = tb_dq_en ? tb_dq : 'z;

  sram_device_model #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .READ_LAT  (READ_LAT),
    .WRITE_LAT (WRITE_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SRAM_ADDR(sram_addr),
    .SRAM_WE_N(sram_we_n),
    .SRAM_DQ  (dq_bus),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin : ref_model
    int idx;
    idx = int'(sram_addr) % DEPTH;
    if (rst) begin
      m_fresh = 1'b1;
      m_drv   = 1'b0;
      m_init  = INIT_CYCLES;
    end else if (m_init > 0) begin
      m_init = m_init - 1;
      if (m_init == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          ref_mem[i]   = '0;
          ref_known[i] = 1'b1;
        end
      end
    end else if (m_fresh || (sram_addr != m_addr) || (sram_we_n != m_we)) begin
      m_fresh = 1'b0;
      m_addr  = sram_addr;
      m_we    = sram_we_n;
      m_age   = 1;
      m_drv   = 1'b0;
    end else begin
      m_age = m_age + 1;
      if (m_we && (m_age == READ_LAT + 1)) begin
        m_rd       = ref_mem[idx];
        m_rd_known = ref_known[idx];
        m_drv      = 1'b1;
      end
      if (!m_we && (m_age == WRITE_LAT + 1)) begin
        ref_mem[idx]   = tb_dq;
        ref_known[idx] = 1'b1;
      end
    end
  end

  // High-Z reads as unknown on a 4-state simulator and as zero on a 2-state one.
  function automatic bit bus_released();
    return $isunknown(dq_bus) || (dq_bus == 64'h0);
  endfunction

  task automatic drive(input logic [16:0] a, input logic we, input logic [63:0] d);
    @(negedge clk);
    sram_addr = a;
    sram_we_n = we;
    tb_dq     = d;
    tb_dq_en  = !we;
    #1;
  endtask

  task automatic wait_init();
    for (int n = 0; n < 4 * DEPTH && m_init > 0; n++) drive(PARK, 1'b1, '0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(17'($urandom), 1'b1, '0);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy: got %b want 0", busy);
      end
      checks++;
      if (!bus_released()) begin
        errors++;
        $display("FAIL reset_dq_release: got %h want high-Z", dq_bus);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int n = 0; n < 4 * DEPTH && m_init > 0; n++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL init_busy_high: got %b want 1", busy);
      end
      drive(PARK, 1'b1, '0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_reset: got %b want 0", busy);
    end
  endtask

  task automatic test_write_read();
    logic [63:0] d;
    d = 64'h1122334455667788;
    drive(PARK, 1'b1, '0);
    repeat (WRITE_LAT + 1) drive(17'h00005, 1'b0, d);
    for (int e = 0; e < READ_LAT + 3; e++) begin
      drive(17'h00005, 1'b1, '0);
      checks++;
      if (e >= READ_LAT + 1) begin
        if (dq_bus !== d) begin
          errors++;
          $display("FAIL rd_latency_data edge %0d: got %h want %h", e, dq_bus, d);
        end
      end else if (!bus_released()) begin
        errors++;
        $display("FAIL rd_latency_early edge %0d: got %h want high-Z", e, dq_bus);
      end
    end
  endtask

  task automatic test_short_write();
    logic [63:0] d_old;
    d_old = 64'h5555000000001234;
    drive(PARK, 1'b1, '0);
    repeat (WRITE_LAT + 1) drive(17'h00007, 1'b0, d_old);
    drive(PARK, 1'b1, '0);
    drive(17'h00007, 1'b0, 64'hAAAA);
    drive(PARK, 1'b1, '0);
    repeat (READ_LAT + 2) drive(17'h00007, 1'b1, '0);
    checks++;
    if (dq_bus !== d_old) begin
      errors++;
      $display("FAIL short_write_ignored: got %h want %h", dq_bus, d_old);
    end
  endtask

  task automatic test_read_abort();
    logic [63:0] d;
    d = 64'h0F0F123456789ABC;
    drive(PARK, 1'b1, '0);
    repeat (WRITE_LAT + 1) drive(17'h00010, 1'b0, d);
    drive(PARK, 1'b1, '0);
    repeat (READ_LAT + 2) drive(17'h00010, 1'b1, '0);
    checks++;
    if (dq_bus !== d) begin
      errors++;
      $display("FAIL abort_pre_read: got %h want %h", dq_bus, d);
    end
    @(negedge clk);
    sram_we_n = 1'b0;
    tb_dq_en  = 1'b0;
    #1;
    checks++;
    if (!bus_released()) begin
      errors++;
      $display("FAIL abort_release: got %h want high-Z", dq_bus);
    end
    tb_dq    = '0;
    tb_dq_en = 1'b1;
    #1;
    checks++;
    if (dq_bus !== 64'h0) begin
      errors++;
      $display("FAIL abort_contention: got %h want %h", dq_bus, 64'h0);
    end
    drive(PARK, 1'b1, '0);
  endtask

  task automatic test_alias();
    drive(PARK, 1'b1, '0);
    repeat (WRITE_LAT + 1) drive(17'h00003, 1'b0, 64'hDEAD);
    drive(PARK, 1'b1, '0);
    repeat (READ_LAT + 2) drive(17'h00103, 1'b1, '0);
    checks++;
    if (dq_bus !== 64'hDEAD) begin
      errors++;
      $display("FAIL alias_read: got %h want %h", dq_bus, 64'hDEAD);
    end
  endtask

  task automatic test_long_write();
    logic [63:0] vals [10];
    drive(PARK, 1'b1, '0);
    for (int i = 0; i < 10; i++) begin
      vals[i] = {$urandom, $urandom};
      drive(17'h00009, 1'b0, vals[i]);
    end
    drive(PARK, 1'b1, '0);
    repeat (READ_LAT + 2) drive(17'h00009, 1'b1, '0);
    checks++;
    if (dq_bus !== vals[WRITE_LAT]) begin
      errors++;
      $display("FAIL long_write_single_commit: got %h want %h", dq_bus, vals[WRITE_LAT]);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] da, db, exp;
    da  = 64'hA5A5000011112222;
    db  = 64'h5A5A333344445555;
    exp = (INIT_CYCLES > 0) ? 64'h0 : da;
    drive(PARK, 1'b1, '0);
    repeat (WRITE_LAT + 1) drive(17'h00020, 1'b0, da);
    drive(PARK, 1'b1, '0);
    repeat (READ_LAT + 2) drive(17'h00020, 1'b1, '0);
    checks++;
    if (dq_bus !== da) begin
      errors++;
      $display("FAIL mid_pre_read: got %h want %h", dq_bus, da);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (!bus_released()) begin
      errors++;
      $display("FAIL rst_release: got %h want high-Z", dq_bus);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    wait_init();
    drive(PARK, 1'b1, '0);
    repeat (WRITE_LAT) drive(17'h00020, 1'b0, db);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    wait_init();
    drive(PARK, 1'b1, '0);
    repeat (READ_LAT + 2) drive(17'h00020, 1'b1, '0);
    checks++;
    if (dq_bus !== exp) begin
      errors++;
      $display("FAIL mid_write_discard: got %h want %h", dq_bus, exp);
    end
  endtask

`ifdef SRAM_MODEL_INIT_CLEAR_EN
  task automatic test_init_clear();
    int count;
    drive(PARK, 1'b1, '0);
    repeat (WRITE_LAT + 1) drive(17'h00004, 1'b0, 64'hFF);
    drive(PARK, 1'b1, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    count = 0;
    for (int n = 0; n < DEPTH + 50 && busy === 1'b1; n++) begin
      count++;
      drive(PARK, 1'b1, '0);
    end
    checks++;
    if (count != DEPTH) begin
      errors++;
      $display("FAIL init_busy_cycles: got %0d want %0d", count, DEPTH);
    end
    drive(PARK, 1'b1, '0);
    repeat (READ_LAT + 2) drive(17'h00004, 1'b1, '0);
    checks++;
    if (dq_bus !== 64'h0) begin
      errors++;
      $display("FAIL init_cleared: got %h want 0", dq_bus);
    end
  endtask
`endif

  task automatic test_random();
    logic [16:0] a;
    logic        we;
    int          hold;
    for (int w = 0; w < 150; w++) begin
      a    = (17'($urandom_range(0, 511)) << 8) | 17'($urandom_range(0, 15));
      we   = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 7);
      for (int c = 0; c < hold; c++) begin
        drive(a, we, {$urandom, $urandom});
        checks++;
        if (busy !== (m_init > 0)) begin
          errors++;
          $display("FAIL rand_busy: got %b want %b", busy, (m_init > 0));
        end
        if (!we) begin
          checks++;
          if (dq_bus !== tb_dq) begin
            errors++;
            $display("FAIL rand_wr_contention: got %h want %h", dq_bus, tb_dq);
          end
        end else if (m_drv && (m_addr == a)) begin
          if (m_rd_known) begin
            checks++;
            if (dq_bus !== m_rd) begin
              errors++;
              $display("FAIL rand_rd_data addr %h: got %h want %h", a, dq_bus, m_rd);
            end
          end
        end else begin
          checks++;
          if (!bus_released()) begin
            errors++;
            $display("FAIL rand_rd_release addr %h: got %h want high-Z", a, dq_bus);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_short_write();
    test_read_abort();
    test_alias();
    test_long_write();
    test_reset_mid();
`ifdef SRAM_MODEL_INIT_CLEAR_EN
    test_init_clear();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
